// File: rtl/op_dispatch.sv
// Issue-side controller for the arithmetic unit: accepts one request, launches the
// multiplier, divider or sqrt unit, waits for its done and drives the result-mux select.
module op_dispatch #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         done_m,
  input  logic         done_d,
  input  logic         done_r,
  output logic         start_m,
  output logic         start_d,
  output logic         start_r,
  output logic [N-1:0] opa,
  output logic [N-1:0] opb,
  output logic [1:0]   sel,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  typedef struct packed {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  state_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] opa_n, opb_n;
  logic [1:0]   sel_n;
  logic         err_n, busy_n, done_n;
  logic [2:0]   go_n;
  logic         unit_done, reject;
  req_t         req;

  assign req    = '{op: op, a: a_in, b: b_in};
  assign reject = (req.op == SEL_NONE) || (req.op == OP_DIV && req.b == '0);

  // Only the unit currently selected may end the wait.
  always_comb begin
    unit_done = 1'b0;
    case (sel)
      OP_MUL:  unit_done = done_m;
      OP_DIV:  unit_done = done_d;
      OP_SQRT: unit_done = done_r;
      default: unit_done = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    opa_n   = opa;
    opb_n   = opb;
    sel_n   = sel;
    err_n   = error;
    go_n    = 3'b000;
    case (state)
      IDLE: begin
        if (start) begin
          if (reject) begin
            sel_n   = SEL_NONE;
            err_n   = 1'b1;
            state_n = FINISH;
          end else begin
            opa_n   = req.a;
            opb_n   = (req.op == OP_SQRT) ? '0 : req.b;
            sel_n   = req.op;
            err_n   = 1'b0;
            state_n = LAUNCH;
            case (req.op)
              OP_MUL:  go_n = 3'b001;
              OP_DIV:  go_n = 3'b010;
              default: go_n = 3'b100;
            endcase
          end
        end
      end
      LAUNCH: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + 1'b1;
        if (unit_done) begin
          err_n   = 1'b0;
          state_n = FINISH;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          sel_n   = SEL_NONE;
          state_n = FINISH;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      sel     <= SEL_NONE;
      error   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      start_m <= 1'b0;
      start_d <= 1'b0;
      start_r <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      opa     <= opa_n;
      opb     <= opb_n;
      sel     <= sel_n;
      error   <= err_n;
      busy    <= busy_n;
      done    <= done_n;
      start_m <= go_n[0];
      start_d <= go_n[1];
      start_r <= go_n[2];
    end
  end

endmodule
